axi_lite_sram_slave: RTL and testbench
======================================

Name: axi_lite_sram_slave

Overview:
AXI-lite responder: word-addressed SRAM model that answers the read/write requests issued by the core's fetch and load/store initiators through the crossbar. Sits on one crossbar output port. Read and write channels are independent, each with a configurable response latency, so initiator handshake logic is exercised under non-zero wait states.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two
BASE_ADDR, 32'h8000_0000, byte address of word 0
RD_LAT, 1, cycles from AR accept to rvalid assertion; >=1
WR_LAT, 1, cycles from AW+W both accepted to bvalid assertion; >=1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
araddr  in  32  read byte address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data
rresp  out  1  0=OKAY, 1=error
rvalid  out  1  read data valid
rready  in  1  read data ready
awaddr  in  32  write byte address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte enables, bit i -> wdata[8i+7:8i]
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  1  0=OKAY, 1=error
bvalid  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset: read FSM R_IDLE, write FSM W_IDLE; arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0. Memory contents not reset. Reset mid-transaction abandons it; no pending write commits.
- Handshake: transfer when valid&ready on the same rising edge. Outputs registered; rvalid/bvalid held until accepted, rdata/rresp/bresp stable while valid.
- Address map: off = addr - BASE_ADDR; in range iff off < DEPTH*4; word index = off[log2(DEPTH)+1:2]; addr[1:0] ignored.
- Read FSM: R_IDLE (arready=1): on AR handshake latch addr, counter=RD_LAT-1 -> R_WAIT (arready=0). R_WAIT: counter==0 -> R_RESP, sample mem into rdata, rvalid=1; else decrement. R_RESP: on rready -> R_IDLE, rvalid=0, arready=1. RD_LAT=1: rvalid asserts the cycle after AR handshake.
- Read out of range: rdata=0, rresp=1, same timing.
- Write FSM: W_IDLE: awready/wready each drop individually once that channel is captured; AW and W may arrive in either order or together. Both captured -> counter=WR_LAT-1 -> W_WAIT. W_WAIT: counter==0 -> commit strobed bytes, bvalid=1 -> W_RESP. W_RESP: on bready -> W_IDLE, awready=wready=1.
- Write out of range: no memory change, bresp=1.
- wstrb=0: no change, bresp=0.
- Same-cycle read sample and write commit to one word: read returns pre-write data.
- Channels fully concurrent; one outstanding transaction per direction.

Optional Feature:
AXI_SRAM_RAND_DELAY_EN: defined -> latency counters reloaded with RD_LAT-1 / WR_LAT-1 plus a 2-bit value from an internal 16-bit LFSR (taps 16,14,13,11; reset seed 16'hACE1; advances every cycle), giving latency RD_LAT..RD_LAT+3. Undefined -> fixed latency exactly as above; no LFSR logic.

Decomposition:
- Shared package: resp codes RESP_OKAY=1'b0, RESP_ERR=1'b1; read-FSM and write-FSM state encodings; LFSR seed/taps constants.
- One sub-module natural: axi_lite_lfsr16 (enable, seed, 16-bit out), instantiated only under AXI_SRAM_RAND_DELAY_EN.

Test Plan:
- Write awaddr=0x8000_0010, wdata=0xDEADBEEF, wstrb=4'hF, AW and W same cycle; bready=1 -> bvalid 1 cycle after accept (WR_LAT=1), bresp=0; read same addr -> rdata=0xDEADBEEF, rresp=0.
- wstrb=4'b0101, wdata=0x11223344 over 0xDEADBEEF -> readback 0xDE22BE44.
- W three cycles before AW -> wready low after W accept, awready still high; bvalid only after AW accept + WR_LAT.
- Read araddr=0x8000_1000 with DEPTH=1024 -> rresp=1, rdata=0; write there -> bresp=1, no aliasing into word 0.
- rready held low 5 cycles -> rvalid and rdata stable, arready=0 throughout; arready=1 cycle after rready handshake.
- Assert rst in R_WAIT and W_WAIT -> next cycle rvalid=bvalid=0, all readies=1; pending write absent from memory.

Source files
------------

// File: rtl/axi_lite_sram_pkg.sv
// Shared definitions for the AXI-lite SRAM responder: response codes, FSM encodings, LFSR constants.
// The LFSR constants are used only when the AXI_SRAM_RAND_DELAY_EN build option is enabled.
package axi_lite_sram_pkg;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axi_lite_sram_slave_lfsr.sv
// 16-bit Fibonacci LFSR that advances every enabled cycle and loads its seed on reset.
// It supplies the random extra wait states for the AXI-lite SRAM responder.
module axi_lite_lfsr16
    import axi_lite_sram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [15:0] seed_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed_i;
        end else if (en_i) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI-lite word-addressed SRAM responder with independent read/write FSMs and configurable response latency.
// Defining AXI_SRAM_RAND_DELAY_EN adds 0..3 LFSR-driven extra wait states per transaction.
module axi_lite_sram_slave
    import axi_lite_sram_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          RD_LAT    = 1,
    parameter int          WR_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic        bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam int          CNT_W = 16;
    localparam logic [32:0] SPAN  = 33'(DEPTH) * 33'd4;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return {1'b0, off} < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    logic [31:0] mem [DEPTH];

    logic [1:0] rd_extra;
    logic [1:0] wr_extra;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;

    axi_lite_lfsr16 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (1'b1),
        .seed_i (LFSR_SEED),
        .lfsr_o (lfsr)
    );

    assign rd_extra = lfsr[1:0];
    assign wr_extra = lfsr[3:2];
`else
    assign rd_extra = 2'b00;
    assign wr_extra = 2'b00;
`endif

    logic [CNT_W-1:0] rd_reload;
    logic [CNT_W-1:0] wr_reload;

    assign rd_reload = CNT_W'(RD_LAT - 1) + CNT_W'(rd_extra);
    assign wr_reload = CNT_W'(WR_LAT - 1) + CNT_W'(wr_extra);

    // Read channel
    rd_state_e        rd_state_q;
    logic [CNT_W-1:0] rcnt_q;
    logic [31:0]      raddr_q;
    logic [31:0]      rdata_q;
    logic             rresp_q;
    logic             rvalid_q;
    logic             arready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rcnt_q     <= '0;
            raddr_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        raddr_q    <= araddr;
                        rcnt_q     <= rd_reload;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rcnt_q == '0) begin
                        rvalid_q   <= 1'b1;
                        rd_state_q <= R_RESP;
                        if (in_range(raddr_q)) begin
                            rdata_q <= mem[word_idx(raddr_q)];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_ERR;
                        end
                    end else begin
                        rcnt_q <= rcnt_q - 1'b1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    // Write channel: AW and W are captured independently, in either order.
    wr_state_e        wr_state_q;
    logic [CNT_W-1:0] wcnt_q;
    logic [31:0]      waddr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic             bresp_q;
    logic             bvalid_q;
    logic             awready_q;
    logic             wready_q;
    logic             aw_have_d;
    logic             w_have_d;
    logic             wr_commit;

    assign aw_have_d = !awready_q || awvalid;
    assign w_have_d  = !wready_q  || wvalid;
    assign wr_commit = (wr_state_q == W_WAIT) && (wcnt_q == '0) && in_range(waddr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wcnt_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (awvalid && awready_q) begin
                        waddr_q   <= awaddr;
                        awready_q <= 1'b0;
                    end
                    if (wvalid && wready_q) begin
                        wdata_q  <= wdata;
                        wstrb_q  <= wstrb;
                        wready_q <= 1'b0;
                    end
                    if (aw_have_d && w_have_d) begin
                        wcnt_q     <= wr_reload;
                        wr_state_q <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (wcnt_q == '0) begin
                        bvalid_q   <= 1'b1;
                        bresp_q    <= in_range(waddr_q) ? RESP_OKAY : RESP_ERR;
                        wr_state_q <= W_RESP;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Reset on the commit edge drops the pending write.
    always_ff @(posedge clk) begin
        if (wr_commit && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[word_idx(waddr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign arready = arready_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rvalid  = rvalid_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Bench for axi_lite_sram_slave: scenario tasks with a reference word model and expectation queues.
module tb_axi_lite_sram_slave;

    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          RD_LAT = 1;
    localparam int          WR_LAT = 1;
    localparam int          TMO    = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic        rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    axi_lite_sram_slave #(
        .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        resp;
    } rexp_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] model [int];
    rexp_t       rq [$];
    logic        bq [$];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic model_write(input logic [31:0] a, input logic [31:0] d,
                                         input logic [3:0] s);
        logic [31:0] off;
        int          i;
        off = a - BASE;
        if (off >= 32'(DEPTH * 4)) return 1'b1;
        i = int'(off >> 2);
        model[i] = merge(model.exists(i) ? model[i] : 32'h0, d, s);
        return 1'b0;
    endfunction

    function automatic rexp_t model_read(input logic [31:0] a);
        logic [31:0] off;
        rexp_t       e;
        off = a - BASE;
        if (off >= 32'(DEPTH * 4)) begin
            e.data = '0;
            e.resp = 1'b1;
        end else begin
            e.data = model[int'(off >> 2)];
            e.resp = 1'b0;
        end
        return e;
    endfunction

    task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic resp, output int lat, output bit ok);
        bit hs_aw, hs_w;
        int n;
        ok = 1'b1;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < TMO) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            if (hs_aw) awvalid = 1'b0;
            if (hs_w)  wvalid  = 1'b0;
            n++;
        end
        if (awvalid || wvalid) ok = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bvalid) ok = 1'b0;
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic rd_txn(input logic [31:0] a, output logic [31:0] d, output logic resp,
                          output int lat, output bit ok);
        int n;
        ok = 1'b1;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (arvalid && n < TMO) begin
            if (arready) begin
                @(posedge clk); #1;
                arvalid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        if (arvalid) ok = 1'b0;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rvalid) ok = 1'b0;
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_chk++;
        if ({arready, awready, wready, rvalid, bvalid, rresp, bresp} !== 7'b1110000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got {ar,aw,w,rv,bv,rr,br}=%b, required 1110000",
                     {arready, awready, wready, rvalid, bvalid, rresp, bresp});
        end
        n_chk++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h, required 00000000", rdata);
        end
    endtask

    task automatic test_basic();
        logic r, eb; logic [31:0] d; int lat; bit ok; rexp_t e;
        bq.push_back(model_write(32'h8000_0010, 32'hDEADBEEF, 4'hF));
        wr_txn(32'h8000_0010, 32'hDEADBEEF, 4'hF, r, lat, ok);
        eb = bq.pop_front();
        n_chk++;
        if (!ok || r !== eb || lat != WR_LAT) begin
            n_fail++;
            $display("FAIL basic_write: ok=%0d bresp=%b lat=%0d, required ok=1 bresp=%b lat=%0d",
                     ok, r, lat, eb, WR_LAT);
        end
        rq.push_back(model_read(32'h8000_0010));
        rd_txn(32'h8000_0010, d, r, lat, ok);
        e = rq.pop_front();
        n_chk++;
        if (!ok || d !== e.data || r !== e.resp || lat != RD_LAT) begin
            n_fail++;
            $display("FAIL basic_read: ok=%0d rdata=%h rresp=%b lat=%0d, required %h/%b lat=%0d",
                     ok, d, r, lat, e.data, e.resp, RD_LAT);
        end
    endtask

    task automatic test_strobe();
        logic r, eb; logic [31:0] d; int lat; bit ok;
        bq.push_back(model_write(32'h8000_0010, 32'h11223344, 4'b0101));
        wr_txn(32'h8000_0010, 32'h11223344, 4'b0101, r, lat, ok);
        eb = bq.pop_front();
        n_chk++;
        if (!ok || r !== eb) begin
            n_fail++;
            $display("FAIL strobe_write: ok=%0d bresp=%b, required bresp=%b", ok, r, eb);
        end
        rd_txn(32'h8000_0010, d, r, lat, ok);
        n_chk++;
        if (!ok || d !== 32'hDE22BE44 || r !== 1'b0) begin
            n_fail++;
            $display("FAIL strobe_read: ok=%0d rdata=%h rresp=%b, required DE22BE44/0", ok, d, r);
        end
        bq.push_back(model_write(32'h8000_0010, 32'hFFFFFFFF, 4'b0000));
        wr_txn(32'h8000_0010, 32'hFFFFFFFF, 4'b0000, r, lat, ok);
        eb = bq.pop_front();
        rq.push_back(model_read(32'h8000_0010));
        rd_txn(32'h8000_0010, d, r, lat, ok);
        n_chk++;
        if (!ok || d !== rq[0].data || r !== eb) begin
            n_fail++;
            $display("FAIL strobe_zero: ok=%0d rdata=%h bresp=%b, required %h/%b", ok, d, r, rq[0].data, eb);
        end
        void'(rq.pop_front());
    endtask

    task automatic test_w_before_aw();
        int lat; logic [31:0] d; logic r; bit ok; logic eb;
        eb = model_write(32'h8000_0040, 32'hA5A5_5A5A, 4'hF);
        wdata = 32'hA5A5_5A5A; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        n_chk++;
        if (wready !== 1'b0 || awready !== 1'b1) begin
            n_fail++;
            $display("FAIL w_first_ready: wready=%b awready=%b, required 0/1", wready, awready);
        end
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b0) begin
            n_fail++;
            $display("FAIL w_first_hold: bvalid=%b awready=%b wready=%b, required 0/1/0",
                     bvalid, awready, wready);
        end
        awaddr = 32'h8000_0040; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        n_chk++;
        if (bvalid !== 1'b1 || lat != WR_LAT || bresp !== eb) begin
            n_fail++;
            $display("FAIL w_first_bvalid: bvalid=%b lat=%0d bresp=%b, required 1 lat=%0d bresp=%b",
                     bvalid, lat, bresp, WR_LAT, eb);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        rd_txn(32'h8000_0040, d, r, lat, ok);
        n_chk++;
        if (!ok || d !== 32'hA5A5_5A5A || r !== 1'b0) begin
            n_fail++;
            $display("FAIL w_first_read: rdata=%h rresp=%b, required a5a55a5a/0", d, r);
        end
    endtask

    task automatic test_out_of_range();
        logic r, eb; logic [31:0] d; int lat; bit ok; rexp_t e;
        eb = model_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF);
        wr_txn(32'h8000_0000, 32'h0BAD_F00D, 4'hF, r, lat, ok);
        rq.push_back(model_read(32'h8000_1000));
        rd_txn(32'h8000_1000, d, r, lat, ok);
        e = rq.pop_front();
        n_chk++;
        if (!ok || d !== e.data || r !== e.resp || lat != RD_LAT) begin
            n_fail++;
            $display("FAIL oor_read: rdata=%h rresp=%b lat=%0d, required %h/%b lat=%0d",
                     d, r, lat, e.data, e.resp, RD_LAT);
        end
        bq.push_back(model_write(32'h8000_1000, 32'hCAFE_F00D, 4'hF));
        wr_txn(32'h8000_1000, 32'hCAFE_F00D, 4'hF, r, lat, ok);
        eb = bq.pop_front();
        n_chk++;
        if (!ok || r !== eb) begin
            n_fail++;
            $display("FAIL oor_write: bresp=%b, required %b", r, eb);
        end
        rd_txn(32'h8000_0000, d, r, lat, ok);
        n_chk++;
        if (!ok || d !== 32'h0BAD_F00D || r !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_alias: word0=%h rresp=%b, required 0badf00d/0", d, r);
        end
        rq.push_back(model_read(32'h7FFF_FFFC));
        rd_txn(32'h7FFF_FFFC, d, r, lat, ok);
        e = rq.pop_front();
        n_chk++;
        if (!ok || d !== e.data || r !== e.resp) begin
            n_fail++;
            $display("FAIL below_base: rdata=%h rresp=%b, required %h/%b", d, r, e.data, e.resp);
        end
        eb = model_write(32'h8000_0FFF, 32'h7777_1234, 4'hF);
        wr_txn(32'h8000_0FFF, 32'h7777_1234, 4'hF, r, lat, ok);
        rq.push_back(model_read(32'h8000_0FFC));
        rd_txn(32'h8000_0FFC, d, r, lat, ok);
        e = rq.pop_front();
        n_chk++;
        if (!ok || d !== e.data || r !== e.resp || eb !== 1'b0) begin
            n_fail++;
            $display("FAIL last_word: rdata=%h rresp=%b, required %h/%b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_rready_stall();
        int lat; rexp_t e;
        rq.push_back(model_read(32'h8000_0010));
        araddr = 32'h8000_0010; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        e = rq.pop_front();
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp || arready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_c%0d: rvalid=%b rdata=%h arready=%b, required 1/%h/0",
                         c, rvalid, rdata, arready, e.data);
            end
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        n_chk++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: rvalid=%b arready=%b, required 0/1", rvalid, arready);
        end
    endtask

    task automatic test_same_cycle();
        logic r; logic [31:0] d; int lat; bit ok; rexp_t e; logic eb;
        eb = model_write(32'h8000_0030, 32'h0102_0304, 4'hF);
        wr_txn(32'h8000_0030, 32'h0102_0304, 4'hF, r, lat, ok);
        rq.push_back(model_read(32'h8000_0030));
        bq.push_back(model_write(32'h8000_0030, 32'hA0B0_C0D0, 4'hF));
        araddr = 32'h8000_0030; arvalid = 1'b1;
        awaddr = 32'h8000_0030; awvalid = 1'b1;
        wdata = 32'hA0B0_C0D0; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        e = rq.pop_front();
        eb = bq.pop_front();
        n_chk++;
        if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== e.data || bresp !== eb) begin
            n_fail++;
            $display("FAIL same_cycle: rvalid=%b bvalid=%b rdata=%h bresp=%b, required 1/1/%h/%b",
                     rvalid, bvalid, rdata, bresp, e.data, eb);
        end
        rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        rq.push_back(model_read(32'h8000_0030));
        rd_txn(32'h8000_0030, d, r, lat, ok);
        e = rq.pop_front();
        n_chk++;
        if (!ok || d !== e.data || r !== e.resp) begin
            n_fail++;
            $display("FAIL same_cycle_after: rdata=%h, required %h", d, e.data);
        end
    endtask

    task automatic test_reset_midflight();
        logic r; logic [31:0] d; int lat; bit ok; logic eb;
        eb = model_write(32'h8000_0020, 32'hAAAA_AAAA, 4'hF);
        wr_txn(32'h8000_0020, 32'hAAAA_AAAA, 4'hF, r, lat, ok);
        araddr = 32'h8000_0010; arvalid = 1'b1;
        awaddr = 32'h8000_0020; awvalid = 1'b1;
        wdata = 32'h5555_5555; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_chk++;
        if ({rvalid, bvalid, arready, awready, wready} !== 5'b00111) begin
            n_fail++;
            $display("FAIL reset_mid: {rv,bv,ar,aw,w}=%b, required 00111",
                     {rvalid, bvalid, arready, awready, wready});
        end
        rq.push_back(model_read(32'h8000_0020));
        rd_txn(32'h8000_0020, d, r, lat, ok);
        n_chk++;
        if (!ok || d !== rq[0].data || r !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_commit: rdata=%h, required %h", d, rq[0].data);
        end
        void'(rq.pop_front());
    endtask

    task automatic test_back_to_back();
        logic r, eb; logic [31:0] a, d; logic [3:0] s; int lat; bit ok; rexp_t e;
        for (int i = 0; i < 8; i++) begin
            a = BASE + 32'(4 * (64 + i));
            bq.push_back(model_write(a, $urandom, 4'hF));
            wr_txn(a, model[64 + i], 4'hF, r, lat, ok);
            void'(bq.pop_front());
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            bq.push_back(model_write(a, d, s));
            wr_txn(a, d, s, r, lat, ok);
            eb = bq.pop_front();
            n_chk++;
            if (!ok || r !== eb) begin
                n_fail++;
                $display("FAIL b2b_write%0d: bresp=%b, required %b", i, r, eb);
            end
        end
        for (int i = 0; i < 8; i++) rq.push_back(model_read(BASE + 32'(4 * (64 + i))));
        for (int i = 0; i < 8; i++) begin
            rd_txn(BASE + 32'(4 * (64 + i)), d, r, lat, ok);
            e = rq.pop_front();
            n_chk++;
            if (!ok || d !== e.data || r !== e.resp || lat != RD_LAT) begin
                n_fail++;
                $display("FAIL b2b_read%0d: rdata=%h rresp=%b lat=%0d, required %h/%b lat=%0d",
                         i, d, r, lat, e.data, e.resp, RD_LAT);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_w_before_aw();
        test_out_of_range();
        test_rready_stall();
        test_same_cycle();
        test_reset_midflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
